// File: rtl/lin_class_pkg.sv
// rtl/lin_class_pkg.sv - shared widths and record types for the lin_class host
// Contents: PIX_W/SUM_W/LAT constants, res_t result record, trip_t pixel triplet.
package lin_class_pkg;

    localparam int PIX_W = 6;
    localparam int SUM_W = 16;
    localparam int LAT   = 3;

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic             pos;
    } res_t;

    typedef struct packed {
        logic [PIX_W-1:0] im1;
        logic [PIX_W-1:0] im2;
        logic [PIX_W-1:0] im3;
    } trip_t;

endpackage

// File: rtl/lin_class_host_if.sv
// rtl/lin_class_host_if.sv - signal bundle between lin_class_host and its surroundings
// Ports (slave = host view): pixel stream in, triplet out to classifier,
// classifier result in, result stream out, counter clear in, counters out.
interface lin_class_host_if #(
    parameter int CNT_W = 16
);
    import lin_class_pkg::*;

    logic             i_pix_valid;
    logic [PIX_W-1:0] i_pix;
    logic             o_pix_ready;
    logic [PIX_W-1:0] o_im1;
    logic [PIX_W-1:0] o_im2;
    logic [PIX_W-1:0] o_im3;
    logic [SUM_W-1:0] i_wgt_sum;
    logic             i_pos;
    logic             o_res_valid;
    logic [SUM_W-1:0] o_res_sum;
    logic             o_res_pos;
    logic             i_res_ready;
    logic             i_clr;
    logic [CNT_W-1:0] o_cnt_total;
    logic [CNT_W-1:0] o_cnt_pos;

    modport slave (
        input  i_pix_valid, i_pix, i_wgt_sum, i_pos, i_res_ready, i_clr,
        output o_pix_ready, o_im1, o_im2, o_im3, o_res_valid, o_res_sum, o_res_pos,
               o_cnt_total, o_cnt_pos
    );

    modport master (
        output i_pix_valid, i_pix, i_wgt_sum, i_pos, i_res_ready, i_clr,
        input  o_pix_ready, o_im1, o_im2, o_im3, o_res_valid, o_res_sum, o_res_pos,
               o_cnt_total, o_cnt_pos
    );

endinterface

// File: rtl/lin_res_fifo.sv
// rtl/lin_res_fifo.sv - synchronous result FIFO with registered head and count
// Ports: i_clk, i_rst_n (sync, active-low); i_push/i_din write side;
// i_pop read side (ignored when empty); o_dout registered head (0 when empty);
// o_count occupancy.
module lin_res_fifo
    import lin_class_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  res_t                     i_din,
    input  logic                     i_pop,
    output res_t                     o_dout,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    res_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          pop;
    res_t          head_next;

    assign pop     = i_pop && (count != '0);
    assign o_count = count;

    // Head is precomputed for the next cycle so o_dout comes straight from a flop.
    // When the next head slot is the one being written now, bypass the write data.
    always_comb begin
        rd_next    = pop ? rd_ptr + 1'b1 : rd_ptr;
        count_next = count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, pop};
        head_next  = '0;
        if (count_next == '0) begin
            head_next = '0;
        end else if (i_push && (rd_next == wr_ptr)) begin
            head_next = i_din;
        end else begin
            head_next = mem[rd_next];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            mem[wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            o_dout <= '0;
        end else begin
            if (i_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            o_dout <= head_next;
        end
    end

    // Credits upstream must make a push into a full FIFO impossible unless a pop frees a slot.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && !pop && (count == (AW+1)'(DEPTH))));

endmodule

// File: rtl/lin_class_host.sv
// rtl/lin_class_host.sv - pixel triplet feeder and result collector around lin_class
// Ports: i_clk, i_rst_n (sync, active-low); bus (lin_class_host_if.slave):
// pixel stream in with ready, registered im1..im3 to the classifier,
// classifier wgt_sum/pos in, result stream out, i_clr and saturating counters.
module lin_class_host
    import lin_class_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    lin_class_host_if.slave   bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic             ready_q;
    logic [1:0]       idx;
    logic             full;
    trip_t            slots;
    trip_t            trip_q;
    logic             issue_q;
    logic [LAT-1:0]   vld_sr;
    logic [2:0]       inflight;
    logic             accept;
    logic             issue;
    logic             push;
    logic [CW-1:0]    fifo_count;
    res_t             push_data;
    res_t             head;
    logic [CNT_W-1:0] cnt_total;
    logic [CNT_W-1:0] cnt_pos;

    assign bus.o_pix_ready = ready_q && !full;
    assign accept          = bus.i_pix_valid && bus.o_pix_ready;

    // issue_q marks the cycle the triplet first sits on o_im*; the classifier's
    // three stages follow it in vld_sr, so the tail bit lines up with i_wgt_sum.
    always_comb begin
        inflight = {2'b00, issue_q};
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + {2'b00, vld_sr[i]};
        end
    end

    // Every in-flight result already owns a FIFO slot; a pop this cycle only
    // frees a credit once fifo_count has updated.
    assign issue = full && ((int'(fifo_count) + int'(inflight)) < DEPTH);
    assign push  = vld_sr[LAT-1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ready_q <= 1'b0;
            idx     <= 2'd0;
            full    <= 1'b0;
            slots   <= '0;
            trip_q  <= '0;
            issue_q <= 1'b0;
            vld_sr  <= '0;
        end else begin
            ready_q <= 1'b1;
            issue_q <= issue;
            vld_sr  <= {vld_sr[LAT-2:0], issue_q};
            if (accept) begin
                case (idx)
                    2'd0:    slots.im1 <= bus.i_pix;
                    2'd1:    slots.im2 <= bus.i_pix;
                    default: slots.im3 <= bus.i_pix;
                endcase
                if (idx == 2'd2) begin
                    idx  <= 2'd0;
                    full <= 1'b1;
                end else begin
                    idx <= idx + 2'd1;
                end
            end
            // accept needs !full and issue needs full, so these never collide.
            if (issue) begin
                trip_q <= slots;
                full   <= 1'b0;
            end
        end
    end

    assign bus.o_im1 = trip_q.im1;
    assign bus.o_im2 = trip_q.im2;
    assign bus.o_im3 = trip_q.im3;

    assign push_data.sum = bus.i_wgt_sum;
    assign push_data.pos = bus.i_pos;

    lin_res_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_din   (push_data),
        .i_pop   (bus.i_res_ready),
        .o_dout  (head),
        .o_count (fifo_count)
    );

    assign bus.o_res_valid = (fifo_count != '0);
    assign bus.o_res_sum   = head.sum;
    assign bus.o_res_pos   = head.pos;

    // Clear has priority over a same-cycle push; that push is not counted.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || bus.i_clr) begin
            cnt_total <= '0;
            cnt_pos   <= '0;
        end else if (push) begin
            if (cnt_total != '1) begin
                cnt_total <= cnt_total + 1'b1;
            end
            if (bus.i_pos && (cnt_pos != '1)) begin
                cnt_pos <= cnt_pos + 1'b1;
            end
        end
    end

    assign bus.o_cnt_total = cnt_total;
    assign bus.o_cnt_pos   = cnt_pos;

endmodule

// File: tb/tb_lin_class_host.sv
// tb/tb_lin_class_host.sv - directed self-checking bench for lin_class_host
module tb_lin_class_host;
    import lin_class_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   valid_pct;
    res_t exp_q[$];

    lin_class_host_if #(.CNT_W(4)) bus ();

    lin_class_host #(
        .DEPTH (4),
        .CNT_W (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    // Stub classifier: three register stages, sum={4'b0,im1,im2}, pos=im3[0].
    logic [15:0] s1, s2, s3;
    logic        p1, p2, p3;
    always_ff @(posedge clk) begin
        s1 <= {4'b0000, bus.o_im1, bus.o_im2};
        p1 <= bus.o_im3[0];
        s2 <= s1;
        p2 <= p1;
        s3 <= s2;
        p3 <= p2;
    end
    assign bus.i_wgt_sum = s3;
    assign bus.i_pos     = p3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every popped head must match the oldest outstanding triplet.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.o_res_valid === 1'b1 && bus.i_res_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                expect_eq("extra_result", {16'h0, bus.o_res_sum}, 32'hFFFF_FFFF);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                expect_eq("res_sum", bus.o_res_sum, e.sum);
                expect_eq("res_pos", bus.o_res_pos, e.pos);
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pix(input logic [5:0] p);
        int n;
        if (valid_pct < 100) begin
            for (int g = 0; g < 20 && $urandom_range(0, 99) >= valid_pct; g++) begin
                step(1);
            end
        end
        bus.i_pix_valid = 1'b1;
        bus.i_pix       = p;
        n = 0;
        while (!bus.o_pix_ready && n < 200) begin
            step(1);
            n++;
        end
        expect_eq("pix_ready_wait", bus.o_pix_ready, 1);
        step(1);
        bus.i_pix_valid = 1'b0;
    endtask

    task automatic send_trip(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        res_t e;
        send_pix(a);
        send_pix(b);
        send_pix(c);
        e.sum = {4'b0000, a, b};
        e.pos = c[0];
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step(1);
            n++;
        end
        step(2);
        expect_eq("drain_left", exp_q.size(), 0);
    endtask

    task automatic clear_cnt();
        bus.i_clr = 1'b1;
        step(1);
        bus.i_clr = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int npos;
        logic [5:0] a, b, c;
        n_checks        = 0;
        n_fail          = 0;
        valid_pct       = 100;
        rst_n           = 1'b0;
        bus.i_pix_valid = 1'b0;
        bus.i_pix       = '0;
        bus.i_res_ready = 1'b1;
        bus.i_clr       = 1'b0;

        // Reset state
        step(3);
        expect_eq("rst_pix_ready", bus.o_pix_ready, 0);
        expect_eq("rst_im1", bus.o_im1, 0);
        expect_eq("rst_im3", bus.o_im3, 0);
        expect_eq("rst_res_valid", bus.o_res_valid, 0);
        expect_eq("rst_res_sum", bus.o_res_sum, 0);
        expect_eq("rst_res_pos", bus.o_res_pos, 0);
        expect_eq("rst_cnt_total", bus.o_cnt_total, 0);
        expect_eq("rst_cnt_pos", bus.o_cnt_pos, 0);
        rst_n = 1'b1;
        step(1);
        expect_eq("rel_pix_ready", bus.o_pix_ready, 1);

        // Basic: 1,2,3 -> sum 0x0042, pos 1, valid 5 cycles after 3rd accept
        send_trip(6'd1, 6'd2, 6'd3);
        n = 0;
        while (!bus.o_res_valid && n < 20) begin
            step(1);
            n++;
        end
        expect_eq("basic_latency", n, 5);
        expect_eq("basic_sum", bus.o_res_sum, 16'h0042);
        expect_eq("basic_pos", bus.o_res_pos, 1);
        expect_eq("basic_im2", bus.o_im2, 2);
        step(2);
        expect_eq("basic_cnt_total", bus.o_cnt_total, 1);
        expect_eq("basic_cnt_pos", bus.o_cnt_pos, 1);

        // Backpressure: 4 issues max, 5th triplet blocks the stream
        clear_cnt();
        bus.i_res_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            send_trip(6'(t + 1), 6'(2 * t + 3), 6'(t % 2));
        end
        expect_eq("bp_ready_drop", bus.o_pix_ready, 0);
        step(8);
        expect_eq("bp_issued", bus.o_cnt_total, 4);
        expect_eq("bp_im1_held", bus.o_im1, 4);
        expect_eq("bp_ready_low", bus.o_pix_ready, 0);
        expect_eq("bp_head_sum", bus.o_res_sum, {4'b0000, 6'd1, 6'd3});
        bus.i_res_ready = 1'b1;
        send_trip(6'd6, 6'd13, 6'd1);
        wait_drain();
        expect_eq("bp_cnt_total", bus.o_cnt_total, 6);
        expect_eq("bp_cnt_pos", bus.o_cnt_pos, 3);

        // Pixel gaps: ~30% valid density over 10 triplets
        clear_cnt();
        valid_pct = 30;
        npos = 0;
        for (int t = 0; t < 10; t++) begin
            a = 6'($urandom_range(0, 63));
            b = 6'($urandom_range(0, 63));
            c = 6'($urandom_range(0, 63));
            npos += int'(c[0]);
            send_trip(a, b, c);
        end
        valid_pct = 100;
        wait_drain();
        expect_eq("gap_cnt_total", bus.o_cnt_total, 10);
        expect_eq("gap_cnt_pos", bus.o_cnt_pos, npos);

        // Reset mid-flight: one result in flight, two pixels of next triplet held
        send_trip(6'd20, 6'd21, 6'd1);
        send_pix(6'd30);
        send_pix(6'd31);
        rst_n = 1'b0;
        step(2);
        expect_eq("mid_rst_pix_ready", bus.o_pix_ready, 0);
        rst_n = 1'b1;
        exp_q.delete();
        step(10);
        expect_eq("mid_no_result", bus.o_res_valid, 0);
        expect_eq("mid_cnt_total", bus.o_cnt_total, 0);
        expect_eq("mid_cnt_pos", bus.o_cnt_pos, 0);
        send_trip(6'd7, 6'd8, 6'd9);
        n = 0;
        while (!bus.o_res_valid && n < 20) begin
            step(1);
            n++;
        end
        expect_eq("mid_fresh_sum", bus.o_res_sum, 16'h01C8);
        expect_eq("mid_fresh_pos", bus.o_res_pos, 1);
        wait_drain();

        // Saturation at CNT_W=4, then clear colliding with a push
        clear_cnt();
        for (int t = 0; t < 17; t++) begin
            send_trip(6'(t), 6'(t + 1), 6'd1);
        end
        wait_drain();
        expect_eq("sat_cnt_total", bus.o_cnt_total, 15);
        expect_eq("sat_cnt_pos", bus.o_cnt_pos, 15);
        send_trip(6'd5, 6'd6, 6'd7);
        step(4);
        bus.i_clr = 1'b1;
        step(1);
        bus.i_clr = 1'b0;
        expect_eq("clr_push_valid", bus.o_res_valid, 1);
        expect_eq("clr_cnt_total", bus.o_cnt_total, 0);
        expect_eq("clr_cnt_pos", bus.o_cnt_pos, 0);
        wait_drain();

        // Push and pop on the same edge with three stored and one in flight
        clear_cnt();
        bus.i_res_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            send_trip(6'(40 + t), 6'(50 + t), 6'(t));
        end
        step(4);
        expect_eq("pp_count_before", dut.u_fifo.o_count, 3);
        expect_eq("pp_total_before", bus.o_cnt_total, 3);
        bus.i_res_ready = 1'b1;
        step(1);
        bus.i_res_ready = 1'b0;
        expect_eq("pp_count_after", dut.u_fifo.o_count, 3);
        expect_eq("pp_total_after", bus.o_cnt_total, 4);
        expect_eq("pp_head_sum", bus.o_res_sum, {4'b0000, 6'd41, 6'd51});
        bus.i_res_ready = 1'b1;
        wait_drain();
        expect_eq("pp_empty", bus.o_res_valid, 0);
        expect_eq("pp_cnt_pos", bus.o_cnt_pos, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
